// File: rtl/uart_cmd_parser_if.sv
// Bundle of the parser's byte-stream, register-bus and response-stream signals.
// The parser drives through the master modport; its environment uses slave.
interface uart_cmd_parser_if #(
  parameter int ADDR_BYTES = 2,
  parameter int DATA_BYTES = 4
);
  logic [7:0]              rx_dat;
  logic                    rx_val;
  logic                    bus_req;
  logic                    bus_we;
  logic [8*ADDR_BYTES-1:0] bus_addr;
  logic [8*DATA_BYTES-1:0] bus_wdat;
  logic                    bus_ack;
  logic [8*DATA_BYTES-1:0] bus_rdat;
  logic [7:0]              tx_dat;
  logic                    tx_val;
  logic                    tx_rdy;
  logic                    drop;

  modport master (
    input  rx_dat, rx_val, bus_ack, bus_rdat, tx_rdy,
    output bus_req, bus_we, bus_addr, bus_wdat, tx_dat, tx_val, drop
  );

  modport slave (
    output rx_dat, rx_val, bus_ack, bus_rdat, tx_rdy,
    input  bus_req, bus_we, bus_addr, bus_wdat, tx_dat, tx_val, drop
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Debug-UART command parser: turns A5-framed binary commands into single
// read/write transactions on a req/ack register bus and streams back a
// response (5A [+ read data]) or a one-byte error code.
module uart_cmd_parser #(
  parameter int ADDR_BYTES    = 2,
  parameter int DATA_BYTES    = 4,
  parameter int FRAME_TIMEOUT = 500000,
  parameter int BUS_TIMEOUT   = 255
) (
  input logic               clk,
  input logic               rst,
  uart_cmd_parser_if.master io
);
  localparam int AW   = 8 * ADDR_BYTES;
  localparam int DW   = 8 * DATA_BYTES;
  localparam int MAXB = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int CW   = $clog2(MAXB + 1);
  localparam int FTW  = $clog2(FRAME_TIMEOUT + 1);
  localparam int BTW  = $clog2(BUS_TIMEOUT + 1);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_WR    = 8'h01;
  localparam logic [7:0] CMD_RD    = 8'h02;
  localparam logic [7:0] RESP_OK   = 8'h5A;
  localparam logic [7:0] ERR_CMD   = 8'hEE;
  localparam logic [7:0] ERR_BUS   = 8'hEB;

  typedef enum logic [2:0] {
    S_SYNC, S_CMD, S_ADDR, S_DATA, S_BUS, S_RESP, S_ERR
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_we, w_we_nxt;
  logic             r_req, w_req_nxt;
  logic [AW-1:0]    r_addr, w_addr_nxt;
  logic [DW-1:0]    r_wdat, w_wdat_nxt;
  logic [DW-1:0]    r_rdat, w_rdat_nxt;
  logic [7:0]       r_tx_dat, w_tx_dat_nxt;
  logic             r_tx_val, w_tx_val_nxt;
  logic [CW-1:0]    r_bcnt, w_bcnt_nxt;
  logic [FTW-1:0]   r_ftmo, w_ftmo_nxt;
  logic [BTW-1:0]   r_btmo, w_btmo_nxt;
  logic             w_drop;

  // Shifted views: new byte enters at the LSB end, oldest falls off the top.
  logic [AW+7:0]    w_addr_sh;
  logic [DW+7:0]    w_wdat_sh;
  logic [DW+7:0]    w_rdat_sh;
  logic             w_tx_hs;

  assign w_addr_sh = {r_addr, io.rx_dat};
  assign w_wdat_sh = {r_wdat, io.rx_dat};
  assign w_rdat_sh = {r_rdat, 8'h00};
  assign w_tx_hs   = r_tx_val & io.tx_rdy;

  // Next-state, datapath and response sequencing for the frame FSM.
  always_comb begin
    w_state_nxt  = r_state;
    w_we_nxt     = r_we;
    w_req_nxt    = r_req;
    w_addr_nxt   = r_addr;
    w_wdat_nxt   = r_wdat;
    w_rdat_nxt   = r_rdat;
    w_tx_dat_nxt = r_tx_dat;
    w_tx_val_nxt = r_tx_val;
    w_bcnt_nxt   = r_bcnt;
    w_ftmo_nxt   = r_ftmo;
    w_btmo_nxt   = r_btmo;
    w_drop       = 1'b0;

    // Inter-byte watchdog: only armed while a frame is partially received.
    if (r_state inside {S_CMD, S_ADDR, S_DATA}) begin
      if (io.rx_val) begin
        w_ftmo_nxt = '0;
      end else if (r_ftmo == FTW'(FRAME_TIMEOUT - 1)) begin
        w_ftmo_nxt  = '0;
        w_state_nxt = S_SYNC;
      end else begin
        w_ftmo_nxt = r_ftmo + 1'b1;
      end
    end

    case (r_state)
      S_SYNC: begin
        w_ftmo_nxt = '0;
        if (io.rx_val && io.rx_dat == SYNC_BYTE) w_state_nxt = S_CMD;
      end

      S_CMD: if (io.rx_val) begin
        w_bcnt_nxt = '0;
        if (io.rx_dat == CMD_WR) begin
          w_we_nxt    = 1'b1;
          w_state_nxt = S_ADDR;
        end else if (io.rx_dat == CMD_RD) begin
          w_we_nxt    = 1'b0;
          w_state_nxt = S_ADDR;
        end else begin
          w_tx_dat_nxt = ERR_CMD;
          w_tx_val_nxt = 1'b1;
          w_state_nxt  = S_ERR;
        end
      end

      S_ADDR: if (io.rx_val) begin
        w_addr_nxt = w_addr_sh[AW-1:0];
        if (r_bcnt == CW'(ADDR_BYTES - 1)) begin
          w_bcnt_nxt = '0;
          if (r_we) begin
            w_state_nxt = S_DATA;
          end else begin
            w_req_nxt   = 1'b1;
            w_btmo_nxt  = '0;
            w_state_nxt = S_BUS;
          end
        end else begin
          w_bcnt_nxt = r_bcnt + 1'b1;
        end
      end

      S_DATA: if (io.rx_val) begin
        w_wdat_nxt = w_wdat_sh[DW-1:0];
        if (r_bcnt == CW'(DATA_BYTES - 1)) begin
          w_bcnt_nxt  = '0;
          w_req_nxt   = 1'b1;
          w_btmo_nxt  = '0;
          w_state_nxt = S_BUS;
        end else begin
          w_bcnt_nxt = r_bcnt + 1'b1;
        end
      end

      S_BUS: begin
        w_drop = io.rx_val;
        if (io.bus_ack) begin
          w_req_nxt    = 1'b0;
          if (!r_we) w_rdat_nxt = io.bus_rdat;
          w_bcnt_nxt   = '0;
          w_tx_dat_nxt = RESP_OK;
          w_tx_val_nxt = 1'b1;
          w_state_nxt  = S_RESP;
        end else if (r_btmo == BTW'(BUS_TIMEOUT - 1)) begin
          w_req_nxt    = 1'b0;
          w_tx_dat_nxt = ERR_BUS;
          w_tx_val_nxt = 1'b1;
          w_state_nxt  = S_ERR;
        end else begin
          w_btmo_nxt = r_btmo + 1'b1;
        end
      end

      S_RESP: begin
        w_drop = io.rx_val;
        if (w_tx_hs) begin
          if (!r_we && r_bcnt != CW'(DATA_BYTES)) begin
            w_tx_dat_nxt = r_rdat[DW-1 -: 8];
            w_rdat_nxt   = w_rdat_sh[DW-1:0];
            w_bcnt_nxt   = r_bcnt + 1'b1;
          end else begin
            w_tx_val_nxt = 1'b0;
            w_state_nxt  = S_SYNC;
          end
        end
      end

      S_ERR: begin
        w_drop = io.rx_val;
        if (w_tx_hs) begin
          w_tx_val_nxt = 1'b0;
          w_state_nxt  = S_SYNC;
        end
      end

      default: w_state_nxt = S_SYNC;
    endcase
  end

  // State and datapath registers; reset aborts any frame or bus cycle at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_SYNC;
      r_we     <= 1'b0;
      r_req    <= 1'b0;
      r_addr   <= '0;
      r_wdat   <= '0;
      r_rdat   <= '0;
      r_tx_dat <= '0;
      r_tx_val <= 1'b0;
      r_bcnt   <= '0;
      r_ftmo   <= '0;
      r_btmo   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_we     <= w_we_nxt;
      r_req    <= w_req_nxt;
      r_addr   <= w_addr_nxt;
      r_wdat   <= w_wdat_nxt;
      r_rdat   <= w_rdat_nxt;
      r_tx_dat <= w_tx_dat_nxt;
      r_tx_val <= w_tx_val_nxt;
      r_bcnt   <= w_bcnt_nxt;
      r_ftmo   <= w_ftmo_nxt;
      r_btmo   <= w_btmo_nxt;
    end
  end

  assign io.bus_req  = r_req;
  assign io.bus_we   = r_we;
  assign io.bus_addr = r_addr;
  assign io.bus_wdat = r_wdat;
  assign io.tx_dat   = r_tx_dat;
  assign io.tx_val   = r_tx_val;
  // Drop flags the discarded byte in the same cycle it is offered.
  assign io.drop     = w_drop & ~rst;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: write, read with tx stall, bad command,
// bus timeout, frame timeout, busy drops and reset during a bus cycle.
module tb_uart_cmd_parser;
  localparam int FT = 40;
  localparam int BT = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_cmd_parser_if #(.ADDR_BYTES(2), .DATA_BYTES(4)) u_if ();

  uart_cmd_parser #(
    .ADDR_BYTES(2), .DATA_BYTES(4), .FRAME_TIMEOUT(FT), .BUS_TIMEOUT(BT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (u_if)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int n_drop = 0;
  logic [7:0] fr[8];

  always @(negedge clk) if (u_if.drop) n_drop <= n_drop + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    u_if.rx_dat = b;
    u_if.rx_val = 1'b1;
    @(posedge clk); #1;
    u_if.rx_val = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] b[8], input int n);
    for (int i = 0; i < n; i++) send_byte(b[i]);
  endtask

  // Waits (bounded) for a byte accepted by the transmitter; handshake lands on the next posedge.
  task automatic get_tx(input string tag, input logic [7:0] exp);
    logic       got = 1'b0;
    logic [7:0] d   = 8'h00;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (u_if.tx_val && u_if.tx_rdy) begin
        got = 1'b1;
        d   = u_if.tx_dat;
      end
    end
    chk({tag, "_seen"}, {31'd0, got}, 32'd1);
    chk(tag, {24'd0, d}, {24'd0, exp});
  endtask

  // Acks d cycles after the first cycle of bus_req; d=0 acks in that first cycle.
  task automatic ack_after(input int d, input logic [31:0] rdat);
    repeat (d) @(posedge clk);
    #1;
    chk("req_before_ack", {31'd0, u_if.bus_req}, 32'd1);
    u_if.bus_rdat = rdat;
    u_if.bus_ack  = 1'b1;
    @(posedge clk); #1;
    u_if.bus_ack  = 1'b0;
    chk("req_after_ack", {31'd0, u_if.bus_req}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    int d0;
    rst = 1'b1;
    u_if.rx_dat = 8'h00; u_if.rx_val = 1'b0;
    u_if.bus_ack = 1'b0; u_if.bus_rdat = '0;
    u_if.tx_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_req",   {31'd0, u_if.bus_req}, 32'd0);
    chk("rst_we",    {31'd0, u_if.bus_we},  32'd0);
    chk("rst_txval", {31'd0, u_if.tx_val},  32'd0);
    chk("rst_drop",  {31'd0, u_if.drop},    32'd0);
    chk("rst_addr",  {16'd0, u_if.bus_addr}, 32'd0);
    chk("rst_wdat",  u_if.bus_wdat,          32'd0);
    chk("rst_txdat", {24'd0, u_if.tx_dat},  32'd0);

    // Write frame, ack three cycles into the request
    fr = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_bytes(fr, 8);
    chk("wr_req",  {31'd0, u_if.bus_req}, 32'd1);
    chk("wr_we",   {31'd0, u_if.bus_we},  32'd1);
    chk("wr_addr", {16'd0, u_if.bus_addr}, 32'h0000_1234);
    chk("wr_wdat", u_if.bus_wdat, 32'hDEAD_BEEF);
    ack_after(3, 32'h0);
    get_tx("wr_resp", 8'h5A);
    @(posedge clk); #1;
    chk("wr_txval_end", {31'd0, u_if.tx_val}, 32'd0);
    chk("wr_no_drop", n_drop, 32'd0);

    // Read frame, ack in the cycle req rises, tx stalled mid-stream
    fr = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
    send_bytes(fr, 4);
    chk("rd_req",  {31'd0, u_if.bus_req}, 32'd1);
    chk("rd_we",   {31'd0, u_if.bus_we},  32'd0);
    chk("rd_addr", {16'd0, u_if.bus_addr}, 32'h0000_0010);
    ack_after(0, 32'hCAFE_F00D);
    get_tx("rd_b0", 8'h5A);
    get_tx("rd_b1", 8'hCA);
    @(posedge clk); #1 u_if.tx_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_val", {31'd0, u_if.tx_val}, 32'd1);
      chk("stall_dat", {24'd0, u_if.tx_dat}, 32'h0000_00FE);
    end
    @(posedge clk); #1 u_if.tx_rdy = 1'b1;
    get_tx("rd_b2", 8'hFE);
    get_tx("rd_b3", 8'hF0);
    get_tx("rd_b4", 8'h0D);

    // Bad command, then a write frame starting right after the error handshake
    fr = '{8'hA5, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_bytes(fr, 2);
    get_tx("badcmd", 8'hEE);
    fr = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    send_bytes(fr, 8);
    chk("b2b_addr", {16'd0, u_if.bus_addr}, 32'h0000_0001);
    chk("b2b_wdat", u_if.bus_wdat, 32'h1122_3344);
    ack_after(1, 32'h0);
    get_tx("b2b_resp", 8'h5A);

    // Bus timeout: request held exactly BT cycles, then EB
    fr = '{8'hA5, 8'h02, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h00, 8'h00};
    send_bytes(fr, 4);
    u_if.tx_rdy = 1'b0;
    cnt = 0;
    repeat (BT + 10) begin
      @(negedge clk);
      if (u_if.bus_req) cnt++;
    end
    chk("btmo_len", cnt, BT);
    @(posedge clk); #1 u_if.tx_rdy = 1'b1;
    get_tx("btmo_code", 8'hEB);

    // Frame timeout: partial frame abandoned silently
    fr = '{8'hA5, 8'h01, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_bytes(fr, 3);
    cnt = 0;
    repeat (FT + 5) begin
      @(negedge clk);
      if (u_if.bus_req || u_if.tx_val) cnt++;
    end
    chk("ftmo_quiet", cnt, 0);
    fr = '{8'hA5, 8'h01, 8'hA5, 8'h78, 8'h01, 8'hA5, 8'h03, 8'h04};
    send_bytes(fr, 8);
    chk("ftmo_req",  {31'd0, u_if.bus_req}, 32'd1);
    chk("ftmo_addr", {16'd0, u_if.bus_addr}, 32'h0000_A578);
    chk("ftmo_wdat", u_if.bus_wdat, 32'h01A5_0304);
    ack_after(2, 32'h0);
    get_tx("ftmo_resp", 8'h5A);

    // Busy drops during BUS and RESP leave the response intact
    d0 = n_drop;
    fr = '{8'hA5, 8'h02, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
    send_bytes(fr, 4);
    send_byte(8'h11);
    send_byte(8'h22);
    chk("drop_bus", n_drop - d0, 2);
    ack_after(0, 32'h1234_5678);
    u_if.tx_rdy = 1'b0;
    send_byte(8'h33);
    chk("drop_resp", n_drop - d0, 3);
    @(posedge clk); #1 u_if.tx_rdy = 1'b1;
    get_tx("drop_b0", 8'h5A);
    get_tx("drop_b1", 8'h12);
    get_tx("drop_b2", 8'h34);
    get_tx("drop_b3", 8'h56);
    get_tx("drop_b4", 8'h78);

    // Reset in the middle of a bus cycle
    fr = '{8'hA5, 8'h02, 8'h00, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00};
    send_bytes(fr, 4);
    chk("rstbus_req_hi", {31'd0, u_if.bus_req}, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("rstbus_req_lo", {31'd0, u_if.bus_req}, 32'd0);
    chk("rstbus_addr",   {16'd0, u_if.bus_addr}, 32'd0);
    rst = 1'b0;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (u_if.tx_val || u_if.bus_req) cnt++;
    end
    chk("rstbus_quiet", cnt, 0);
    fr = '{8'hA5, 8'h01, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h01};
    send_bytes(fr, 8);
    chk("rstbus_wdat", u_if.bus_wdat, 32'h0000_0001);
    ack_after(0, 32'h0);
    get_tx("rstbus_resp", 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
